mont_exp_ctrl: RTL and testbench
================================

// Module: mont_exp_ctrl
// PURPOSE
//  Left-to-right square-and-multiply modular exponentiation sequencer. Sits directly upstream
//  of the Montgomery multiplier: drives its start/operand ports and consumes its result/done.
//  Computes result = x^e mod m, where x is supplied in the Montgomery domain (x*R mod m, R=2^WIDTH).
//  The final Montgomery multiply by 1 leaves the result in the normal domain.
// PARAMETERS
//  WIDTH     512  operand/modulus width, R = 2^WIDTH
//  EXP_WIDTH 512  exponent register width
//  LEN_W     10   width of exponent-length field; must satisfy 2^LEN_W > EXP_WIDTH
// PORTS
//  clk         in   1          single clock, rising edge
//  reset       in   1          synchronous, active-high
//  start       in   1          one-cycle request; all in_* sampled on this cycle
//  in_x_mont   in   WIDTH      base in Montgomery domain, < in_m
//  in_r_mod_m  in   WIDTH      R mod m; initial accumulator value (Montgomery 1)
//  in_m        in   WIDTH      odd modulus
//  in_e        in   EXP_WIDTH  exponent
//  in_e_len    in   LEN_W      exponent bits to process; MSB used is in_e[in_e_len-1]
//  result      out  WIDTH      x^e mod m; valid while done=1, held until the next accepted start
//  done        out  1          one-cycle pulse when result becomes valid
//  busy        out  1          high from the cycle after an accepted start through the done cycle
//  mul_start   out  1          one-cycle start pulse to the multiplier
//  mul_a       out  WIDTH      multiplier operand A
//  mul_b       out  WIDTH      multiplier operand B
//  mul_m       out  WIDTH      multiplier modulus; registered copy of in_m
//  mul_result  in   WIDTH      multiplier output; sampled only on a mul_done cycle
//  mul_done    in   1          multiplier completion pulse
// BEHAVIOUR
//  - Reset: state=IDLE. result, mul_a, mul_b and mul_m = 0. done, busy and mul_start = 0.
//  - Latch (IDLE & start only): X<=in_x_mont, A<=in_r_mod_m, M<=in_m, E<=in_e, idx<=in_e_len.
//  - Operand stability: mul_a, mul_b and mul_m are driven from registers. They stay stable
//    from the mul_start cycle until the matching mul_done is sampled.
//  - Exactly one mul_start per multiply. Exactly one multiply outstanding at any time.
//  - FSM states: IDLE, CHECK, SQ_GO, SQ_WAIT, MU_GO, MU_WAIT, POST_GO, POST_WAIT, FIN.
//  - IDLE: on start, latch operands -> CHECK.
//  - CHECK: if idx==0 -> POST_GO; else idx<=idx-1 -> SQ_GO.
//  - SQ_GO: mul_a=A, mul_b=A, mul_start=1 -> SQ_WAIT.
//  - SQ_WAIT: on mul_done, A<=mul_result. Then -> MU_GO if E[idx]==1, else -> CHECK.
//    (idx is the already-decremented value.)
//  - MU_GO: mul_a=A, mul_b=X, mul_start=1 -> MU_WAIT.
//  - MU_WAIT: on mul_done, A<=mul_result -> CHECK.
//  - POST_GO: mul_a=A, mul_b=1 (zero-extended to WIDTH), mul_start=1 -> POST_WAIT.
//  - POST_WAIT: on mul_done, result<=mul_result -> FIN.
//  - FIN: done=1 for one cycle -> IDLE.
//  - Multiply count = in_e_len + popcount(E[in_e_len-1:0]) + 1.
//  - Cycles start->done = 2 + sum over multiplies of (multiplier latency + 1) + idx checks.
//    Nothing is timing-critical beyond the stability and one-outstanding rules.
//  - start while busy: ignored; latched operands are unaffected.
//  - mul_done outside a *_WAIT state: ignored.
//  - mul_done on the same cycle as mul_start: ignored; it is not the matching completion.
//  - in_e_len==0: no loop iterations; result = Mont(R mod m, 1) = 1 mod m.
//  - in_e_len > EXP_WIDTH: clamp to EXP_WIDTH at latch.
//  - reset mid-operation: the cycle after reset, state=IDLE, done=0, mul_start=0, result=0.
//    The system resets the multiplier on the same reset.
//  - No reduction is done here. The multiplier returns values < m; operands must be < m.
// TESTING  (behavioural multiplier model, WIDTH=16, R=2^16, fixed 5-cycle latency, plus full
//           512-bit runs against the real multiplier)
//  1. m=13, x_mont=6, r_mod_m=3, e=5, len=3 -> result=6 (2^5 mod 13); 6 mul_start pulses;
//     done pulses exactly once.
//  2. m=13, x_mont=6, r_mod_m=3, e=0, len=0 -> result=1; exactly 1 mul_start, with mul_b=1.
//  3. m=13, x_mont=9 (x=3), r_mod_m=3, e=16'hFFFF, len=16 -> result=1; 33 mul_start pulses.
//  4. Re-assert start mid-run of case 1 with different operands -> ignored; result still 6;
//     no extra mul_start.
//  5. Assert reset during the 2nd SQ_WAIT of case 3 -> next cycle busy=0, mul_start=0,
//     result=0. A fresh case 1 then yields 6.
//  6. 512-bit random m (odd), x and e with len=512 against the real multiplier.
//     result must equal the software pow(x,e,m). Check that mul_a/mul_b never change
//     between mul_start and mul_done.

Source files
------------

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for x^e mod m around a Montgomery multiplier.
// Operands to the multiplier are registered and held until its matching completion.
module mont_exp_ctrl #(
  parameter int WIDTH     = 512,
  parameter int EXP_WIDTH = 512,
  parameter int LEN_W     = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x_mont,
  input  logic [WIDTH-1:0]     in_r_mod_m,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [LEN_W-1:0]     in_e_len,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic [WIDTH-1:0]     mul_m,
  input  logic [WIDTH-1:0]     mul_result,
  input  logic                 mul_done
);

  typedef enum logic [3:0] {
    IDLE, CHECK, SQ_GO, SQ_WAIT, MU_GO, MU_WAIT, POST_GO, POST_WAIT, FIN
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(EXP_WIDTH);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t               r_state, w_next;
  logic [WIDTH-1:0]     r_x, r_a, r_m, r_result, r_mul_a, r_mul_b;
  logic [EXP_WIDTH-1:0] r_e;
  logic [LEN_W-1:0]     r_idx;
  logic                 r_mul_start;
  logic [LEN_W-1:0]     w_len;
  logic [EXP_WIDTH-1:0] w_e_sh;
  logic                 w_ebit;
  logic                 w_ack;

  assign w_len  = (in_e_len > LEN_MAX) ? LEN_MAX : in_e_len;
  assign w_e_sh = r_e >> r_idx;
  assign w_ebit = w_e_sh[0];
  // A completion arriving alongside our own start pulse belongs to nothing we issued.
  assign w_ack  = mul_done & ~r_mul_start;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (start) w_next = CHECK;
      CHECK:     w_next = (r_idx == '0) ? POST_GO : SQ_GO;
      SQ_GO:     w_next = SQ_WAIT;
      SQ_WAIT:   if (w_ack) w_next = w_ebit ? MU_GO : CHECK;
      MU_GO:     w_next = MU_WAIT;
      MU_WAIT:   if (w_ack) w_next = CHECK;
      POST_GO:   w_next = POST_WAIT;
      POST_WAIT: if (w_ack) w_next = FIN;
      FIN:       w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x         <= '0;
      r_a         <= '0;
      r_m         <= '0;
      r_e         <= '0;
      r_idx       <= '0;
      r_result    <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_start <= 1'b0;
    end else begin
      r_mul_start <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_x   <= in_x_mont;
          r_a   <= in_r_mod_m;
          r_m   <= in_m;
          r_e   <= in_e;
          r_idx <= w_len;
        end
        CHECK: if (r_idx != '0) r_idx <= r_idx - 1'b1;
        SQ_GO: begin
          r_mul_a     <= r_a;
          r_mul_b     <= r_a;
          r_mul_start <= 1'b1;
        end
        MU_GO: begin
          r_mul_a     <= r_a;
          r_mul_b     <= r_x;
          r_mul_start <= 1'b1;
        end
        POST_GO: begin
          r_mul_a     <= r_a;
          r_mul_b     <= ONE;
          r_mul_start <= 1'b1;
        end
        SQ_WAIT, MU_WAIT: if (w_ack) r_a <= mul_result;
        POST_WAIT:        if (w_ack) r_result <= mul_result;
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign done      = (r_state == FIN);
  assign busy      = (r_state != IDLE);
  assign mul_start = r_mul_start;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign mul_m     = r_m;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl at WIDTH=16 with a 5-cycle behavioural Montgomery multiplier.
module tb_mont_exp_ctrl;
  localparam int W  = 16;
  localparam int EW = 16;
  localparam int LW = 5;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  in_x_mont = '0, in_r_mod_m = '0, in_m = '0;
  logic [EW-1:0] in_e = '0;
  logic [LW-1:0] in_e_len = '0;
  logic [W-1:0]  result, mul_a, mul_b, mul_m;
  logic          done, busy, mul_start;
  logic [W-1:0]  mul_result = '0;
  logic          mul_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // model-owned counters; the directed sequence only takes snapshots of them
  int n_start = 0, n_done = 0, stab_err = 0, overlap_err = 0;
  logic [W-1:0] last_b = '0;

  always #5 clk = ~clk;

  mont_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_x_mont(in_x_mont), .in_r_mod_m(in_r_mod_m), .in_m(in_m),
    .in_e(in_e), .in_e_len(in_e_len),
    .result(result), .done(done), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
    .mul_result(mul_result), .mul_done(mul_done)
  );

  // a*b*2^-16 mod m, bit-serial
  function automatic logic [W-1:0] mont(input logic [W-1:0] a, b, m);
    logic [W+1:0] t;
    t = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[W-1:0];
  endfunction

  logic         pend = 1'b0;
  int           cnt = 0;
  logic [W-1:0] cap_a, cap_b, cap_m;

  always @(posedge clk) begin
    mul_done <= 1'b0;
    if (done) n_done++;
    if (reset) begin
      pend = 1'b0;
      cnt  = 0;
    end else begin
      if (pend) begin
        if (mul_a !== cap_a || mul_b !== cap_b || mul_m !== cap_m) stab_err++;
        cnt--;
        if (cnt == 0) begin
          mul_done   <= 1'b1;
          mul_result <= mont(cap_a, cap_b, cap_m);
          pend = 1'b0;
        end
      end
      if (mul_start) begin
        if (pend) overlap_err++;
        pend   = 1'b1;
        cnt    = LAT;
        cap_a  = mul_a;
        cap_b  = mul_b;
        cap_m  = mul_m;
        last_b = mul_b;
        n_start++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [W-1:0] x, r, m, input logic [EW-1:0] e, input logic [LW-1:0] len);
    @(negedge clk);
    in_x_mont = x; in_r_mod_m = r; in_m = m; in_e = e; in_e_len = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, "_timeout"}, {31'd0, ok}, 32'd1);
  endtask

  // full run: result, multiply count, single done pulse, protocol hygiene
  task automatic run_case(input string tag, input logic [W-1:0] x, r, m, input logic [EW-1:0] e,
                          input logic [LW-1:0] len, input logic [W-1:0] exp_res, input int exp_mul);
    int s0, d0, st0, ov0;
    s0 = n_start; d0 = n_done; st0 = stab_err; ov0 = overlap_err;
    kick(x, r, m, e, len);
    wait_done(tag);
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    @(negedge clk);
    check({tag, "_muls"}, 32'(n_start - s0), 32'(exp_mul));
    check({tag, "_dones"}, 32'(n_done - d0), 32'd1);
    check({tag, "_stable"}, 32'(stab_err - st0), 32'd0);
    check({tag, "_overlap"}, 32'(overlap_err - ov0), 32'd0);
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int s0;
    logic ok;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_result", 32'(result), 32'd0);
    check("rst_ctl", {29'd0, done, busy, mul_start}, 32'd0);
    check("rst_ops", {mul_a, mul_b}, 32'd0);
    check("rst_m", 32'(mul_m), 32'd0);

    // 2^5 mod 13
    run_case("c1", 16'd6, 16'd3, 16'd13, 16'd5, 5'd3, 16'd6, 6);
    // e_len=0: single multiply by one
    run_case("c2", 16'd6, 16'd3, 16'd13, 16'd0, 5'd0, 16'd1, 1);
    check("c2_mulb", 32'(last_b), 32'd1);
    // 3^65535 mod 13
    run_case("c3", 16'd9, 16'd3, 16'd13, 16'hFFFF, 5'd16, 16'd1, 33);
    // e_len above EXP_WIDTH clamps to 16
    run_case("clamp", 16'd9, 16'd3, 16'd13, 16'hFFFF, 5'd31, 16'd1, 33);
    // 2^1 mod 13
    run_case("len1", 16'd6, 16'd3, 16'd13, 16'd1, 5'd1, 16'd2, 3);

    // start while busy must be ignored
    s0 = n_start;
    kick(16'd6, 16'd3, 16'd13, 16'd5, 5'd3);
    repeat (10) @(negedge clk);
    in_x_mont = 16'd4; in_r_mod_m = 16'd5; in_m = 16'd11; in_e = 16'h00FF; in_e_len = 5'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("c4_mulm", 32'(mul_m), 32'd13);
    wait_done("c4");
    check("c4_result", 32'(result), 32'd6);
    @(negedge clk);
    check("c4_muls", 32'(n_start - s0), 32'd6);

    // reset during the second squaring of case 3
    s0 = n_start;
    kick(16'd9, 16'd3, 16'd13, 16'hFFFF, 5'd16);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (n_start - s0 >= 3) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("c5_reach", {31'd0, ok}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("c5_busy", {31'd0, busy}, 32'd0);
    check("c5_mstart", {31'd0, mul_start}, 32'd0);
    check("c5_done", {31'd0, done}, 32'd0);
    check("c5_result", 32'(result), 32'd0);
    run_case("c5b", 16'd6, 16'd3, 16'd13, 16'd5, 5'd3, 16'd6, 6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
